// File: rtl/arm_pkg.sv
// Shared definitions for the ARM datapath: condition codes, NZCV bit positions,
// conditional-execution FSM states and a flag-merge helper.
package arm_pkg;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  // we[1] selects the N,Z group, we[0] the C,V group.
  function automatic logic [3:0] merge_flags(input logic [3:0] cur,
                                             input logic [3:0] nxt,
                                             input logic [1:0] we);
    logic [3:0] res;
    res = cur;
    if (we[1]) begin
      res[FLAG_N] = nxt[FLAG_N];
      res[FLAG_Z] = nxt[FLAG_Z];
    end
    if (we[0]) begin
      res[FLAG_C] = nxt[FLAG_C];
      res[FLAG_V] = nxt[FLAG_V];
    end
    return res;
  endfunction

endpackage

// File: rtl/cond_check.sv
// Purely combinational condition evaluator: 4-bit ARM condition field against NZCV.
// The reserved 1111 encoding evaluates as always-pass.
module cond_check
  import arm_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       cond_ex
);

  logic n, z, c, v;

  assign n = flags[FLAG_N];
  assign z = flags[FLAG_Z];
  assign c = flags[FLAG_C];
  assign v = flags[FLAG_V];

  always_comb begin
    cond_ex = 1'b1;
    case (cond)
      COND_EQ: cond_ex = z;
      COND_NE: cond_ex = ~z;
      COND_CS: cond_ex = c;
      COND_CC: cond_ex = ~c;
      COND_MI: cond_ex = n;
      COND_PL: cond_ex = ~n;
      COND_VS: cond_ex = v;
      COND_VC: cond_ex = ~v;
      COND_HI: cond_ex = c & ~z;
      COND_LS: cond_ex = ~c | z;
      COND_GE: cond_ex = (n == v);
      COND_LT: cond_ex = (n != v);
      COND_GT: cond_ex = ~z & (n == v);
      COND_LE: cond_ex = z | (n != v);
      COND_AL: cond_ex = 1'b1;
      default: cond_ex = 1'b1;
    endcase
  end

endmodule

// File: rtl/cond_unit.sv
// Conditional-execution and NZCV flags unit; gates PC/register/memory writes with zero
// latency and defers register/flag writes of multi-cycle ops until the unit completes.
module cond_unit
  import arm_pkg::*;
(
  input  logic       CLK,
  input  logic       RESETn,
  input  logic [3:0] Cond,
  input  logic [3:0] ALUFlags,
  input  logic [1:0] FlagW,
  input  logic       PCS,
  input  logic       RegW,
  input  logic       MemW,
  input  logic       NoWrite,
  input  logic       MStart,
  input  logic       MBusy,
  input  logic       Stall,
  output logic       PCSrc,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic       MStartOut,
  output logic       Carry,
  output logic [3:0] FlagsQ,
  output logic       CondEx
);

  state_t     state;
  logic [3:0] flags;
  logic       regw_l;
  logic [1:0] flagw_l;
  logic       issue;
  logic       done;

  cond_check u_cond_check (
    .cond    (Cond),
    .flags   (flags),
    .cond_ex (CondEx)
  );

  // Reset is folded in so no write enable can escape while RESETn is low.
  assign issue = RESETn & ~Stall & (state == ST_IDLE);
  assign done  = RESETn & ~Stall & (state == ST_WAIT) & ~MBusy;

  always_comb begin
    PCSrc     = issue & PCS & CondEx;
    MemWrite  = issue & MemW & CondEx;
    MStartOut = issue & MStart & CondEx;
    RegWrite  = (issue & RegW & CondEx & ~NoWrite & ~MStart) | (done & regw_l);
  end

  assign FlagsQ = flags;
  assign Carry  = flags[FLAG_C];

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state   <= ST_IDLE;
      flags   <= 4'b0000;
      regw_l  <= 1'b0;
      flagw_l <= 2'b00;
    end else if (!Stall) begin
      case (state)
        ST_IDLE: begin
          if (CondEx) begin
            if (MStart) begin
              regw_l  <= RegW & ~NoWrite;
              flagw_l <= FlagW;
              state   <= ST_WAIT;
            end else begin
              flags <= merge_flags(flags, ALUFlags, FlagW);
            end
          end
        end
        ST_WAIT: begin
          // First unbusy cycle: the multi-cycle result and its flags are on ALUFlags now.
          if (!MBusy) begin
            flags   <= merge_flags(flags, ALUFlags, flagw_l);
            regw_l  <= 1'b0;
            flagw_l <= 2'b00;
            state   <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
